// File: rtl/load_store_unit.sv
// Load/store unit: turns one byte/half/word request into one or two word beats
// with byte enables, and assembles/extends load data from the returned words.
module load_store_unit #(
  parameter int              SIZE         = 32,
  parameter logic [SIZE-1:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int              ADDR_W       = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [SIZE-1:0]   req_address,
  input  logic [SIZE-1:0]   req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_extension_type,
  output logic              resp_valid,
  output logic [SIZE-1:0]   resp_rdata,
  output logic              resp_error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [SIZE-1:0]   mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [SIZE-1:0]   mem_rdata,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_BEAT0, S_WAIT0, S_BEAT1, S_WAIT1, S_RESP
  } state_t;

  state_t state_q, state_d;

  logic              write_q, ext_q, cross_q, err_q;
  logic [1:0]        size_q, lane_q;
  logic [ADDR_W-1:0] word_q;
  logic [SIZE-1:0]   wdata_q, lo_q, hi_q;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so at most one request is ever in flight.
  logic            accept;
  logic [SIZE-1:0] off;
  logic            req_err, req_cross;
  logic [2:0]      req_n;
  logic            unused_off_hi;

  assign accept        = req_valid && (state_q == S_IDLE);
  assign off           = req_address - BASE_ADDRESS;
  assign req_err       = (req_size == 2'b11) || (req_address < BASE_ADDRESS);
  assign unused_off_hi = ^off[SIZE-1:ADDR_W+2];

  always_comb begin
    case (req_size)
      2'b00:   req_n = 3'd1;
      2'b01:   req_n = 3'd2;
      default: req_n = 3'd4;
    endcase
  end

  assign req_cross = ({1'b0, off[1:0]} + req_n) > 3'd4;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      ext_q   <= 1'b0;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      word_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= req_write;
        ext_q   <= req_extension_type;
        cross_q <= req_cross;
        err_q   <= req_err;
        size_q  <= req_size;
        lane_q  <= off[1:0];
        word_q  <= off[ADDR_W+1:2];
        wdata_q <= req_wdata;
        lo_q    <= '0;
        hi_q    <= '0;
      end
      if (state_q == S_WAIT0) lo_q <= mem_rdata;
      if (state_q == S_WAIT1) hi_q <= mem_rdata;
    end
  end

  // Both beats come from one double-width shift: low half is beat 0, high half beat 1.
  logic [3:0]        mask;
  logic [7:0]        be_wide;
  logic [2*SIZE-1:0] wd_wide;
  logic [SIZE-1:0]   v, load_val;

  always_comb begin
    case (size_q)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

  assign be_wide = {4'b0000, mask} << lane_q;
  assign wd_wide = {{SIZE{1'b0}}, wdata_q} << {lane_q, 3'b000};
  assign v       = SIZE'({hi_q, lo_q} >> {lane_q, 3'b000});

  always_comb begin
    case (size_q)
      2'b00:   load_val = ext_q ? {{(SIZE-8){1'b0}}, v[7:0]}
                                : {{(SIZE-8){v[7]}}, v[7:0]};
      2'b01:   load_val = ext_q ? {{(SIZE-16){1'b0}}, v[15:0]}
                                : {{(SIZE-16){v[15]}}, v[15:0]};
      default: load_val = v;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = 4'b0000;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_error = 1'b0;
    resp_rdata = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_err ? S_RESP : S_BEAT0;
      end
      S_BEAT0: begin
        mem_req   = 1'b1;
        mem_we    = write_q;
        mem_addr  = word_q;
        mem_be    = be_wide[3:0];
        mem_wdata = wd_wide[SIZE-1:0];
        if (!write_q)     state_d = S_WAIT0;
        else if (cross_q) state_d = S_BEAT1;
        else              state_d = S_RESP;
      end
      S_WAIT0: state_d = cross_q ? S_BEAT1 : S_RESP;
      S_BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = write_q;
        mem_addr  = word_q + ADDR_W'(1);
        mem_be    = be_wide[7:4];
        mem_wdata = wd_wide[2*SIZE-1:SIZE];
        state_d   = write_q ? S_RESP : S_WAIT1;
      end
      S_WAIT1: state_d = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        resp_error = err_q;
        resp_rdata = (err_q || write_q) ? '0 : load_val;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule
